fix_mul_arbiter: RTL and testbench
==================================

Name: fix_mul_arbiter

Overview:
- Shares one pipelined fixed-point multiplier (Q(WIDTH-POINT_WIDTH).POINT_WIDTH, fixed latency MUL_LAT) between N_REQ requesters, e.g. parallel conv-window lanes.
- Round-robin arbitration, valid/ready on the request side, registered operand issue.
- Tag pipeline routes each product back to its requester with a requester ID.
- Sits between the conv lane controllers and the external multiplier instance.

Parameters:
- WIDTH, 16, fixpoint operand/result width.
- POINT_WIDTH, 8, fractional bits (informational; scaling is done inside the multiplier).
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 1, multiplier latency in clocks from operands to product (1..4).
- ID_W, 2, requester ID width = clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed operand B, same packing.
- mul_a  out  WIDTH  operand A to multiplier (registered).
- mul_b  out  WIDTH  operand B to multiplier (registered).
- mul_p  in  WIDTH  product from multiplier, valid MUL_LAT cycles after mul_a/mul_b.
- rsp_valid  out  1  product valid; no backpressure.
- rsp_id  out  ID_W  requester index of current product.
- rsp_data  out  WIDTH  product (mul_p passthrough).
- in_flight  out  3  count of issued products not yet returned (0..MUL_LAT+1).

Behaviour:
- Reset (rst_n=0, asynchronous): mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, in_flight=0, tag pipeline cleared, rr pointer=0. req_ready=0 while rst_n=0.
- Arbitration is combinational:
  - Search req_valid starting at index ptr, upward with wrap.
  - The first set bit wins; req_ready = onehot(winner).
  - If no req_valid, req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
- Transfer: req_valid[i] & req_ready[i] at a clk edge.
  - At that edge: mul_a<=req_a[i], mul_b<=req_b[i]; stage-0 tag <= {1, i}; ptr <= (i+1) mod N_REQ.
  - No transfer: mul_a/mul_b hold, stage-0 tag valid<=0, ptr holds.
- One issue per cycle maximum; throughput 1 product/clk. The arbiter never stalls because the multiplier has no backpressure.
- Tag pipeline: MUL_LAT+1 stages of {valid, id}, shifted every cycle.
  - The final stage drives rsp_valid/rsp_id.
  - rsp_data = mul_p (combinational); it is meaningful only when rsp_valid=1.
- Latency: handshake edge at cycle T gives rsp_valid=1 during cycle T+1+MUL_LAT with the matching id/data.
- Ordering: responses are returned in issue order, one per cycle.
- in_flight: +1 on transfer, -1 when rsp_valid=1; both in the same cycle leave it unchanged.
- Fairness: with all requesters continuously valid, the grant order is 0,1,..,N_REQ-1,0,...
  - A requester that drops valid is skipped with no bubble.
- Boundary cases:
  - Single requester continuously valid: granted every cycle.
  - Requester deasserts valid in the same cycle as ptr points to it: the next valid index wins.
  - ptr wraps from N_REQ-1 to 0.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid follows. Stale mul_p values are ignored.
- Arithmetic: no modification of operands or product. Sign handling and truncation belong to the multiplier.

Decomposition:
- Shared package holds:
  - default WIDTH/POINT_WIDTH constants.
  - clog2 function.
  - the {valid,id} tag record layout.
- One sub-module, rr_arbiter (N_REQ, ID_W): inputs req, ptr; outputs onehot grant and encoded id. Purely combinational.
- The pointer register stays in fix_mul_arbiter.

Test Plan:
- Reset then single request:
  - Stimulus: req 0 with a=0x0180 (1.5), b=0x0200 (2.0); multiplier model MUL_LAT=1.
  - Required: req_ready[0]=1 that cycle; mul_a=0x0180 next cycle; rsp_valid=1, rsp_id=0, rsp_data=0x0300 two cycles after the handshake.
- Signed operands:
  - Stimulus: req 2 with a=0xFF00 (-1.0), b=0x0200.
  - Required: rsp_id=2, rsp_data=0xFE00.
- All 4 requesters valid for 8 cycles:
  - Required: grants 0,1,2,3,0,1,2,3.
  - Required: 8 consecutive rsp_valid with ids in the same order; in_flight steady at 2.
- Sparse valids:
  - Stimulus: req_valid=4'b1010 held, ptr=0.
  - Required: grants 1,3,1,3; requesters 0 and 2 never see ready.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 one cycle after two issues.
  - Required: outputs zero immediately (async); no rsp_valid after release; the next grant goes to requester 0.
- No requests:
  - Stimulus: req_valid=0 for 5 cycles.
  - Required: req_ready=0, mul_a/mul_b hold last values, rsp_valid=0, ptr unchanged.

Source files
------------

// File: rtl/fix_mul_arbiter_pkg.sv
// Shared constants, helpers and the tag record for the multiplier arbiter.
package fix_mul_arbiter_pkg;

    localparam int WIDTH_DEF       = 16;
    localparam int POINT_WIDTH_DEF = 8;
    // Widest requester id the tag record can carry (N_REQ up to 8).
    localparam int MAX_ID_W        = 3;

    // Ceiling log2, never below 1 so a single id bit always exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // One tag pipeline stage: product-valid plus the requester it belongs to.
    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fix_mul_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);

    localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);

    logic [ID_W:0] idx;
    logic          found;

    // Walk N_REQ positions starting at ptr; the first requesting index wins.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= NR) idx = idx - NR;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                = 1'b1;
                grant[idx[ID_W-1:0]] = 1'b1;
                id                   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fix_mul_arbiter.sv
// Shares one pipelined fixed-point multiplier among N_REQ requesters,
// round-robin, and routes each product back with its requester id.
module fix_mul_arbiter
    import fix_mul_arbiter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int POINT_WIDTH = POINT_WIDTH_DEF,
    parameter int N_REQ       = 4,
    parameter int MUL_LAT     = 1,
    parameter int ID_W        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_p,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [2:0]             in_flight
);

    // Reject parameter sets the tag record or counter cannot represent.
    if (N_REQ < 2 || N_REQ > 8 || MUL_LAT < 1 || MUL_LAT > 4 ||
        ID_W != clog2(N_REQ) || POINT_WIDTH >= WIDTH) begin : g_bad_param
        $error("fix_mul_arbiter: illegal parameter set");
    end

    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_id;
    logic             xfer;
    tag_t             tag_pipe [MUL_LAT:0];

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (win_id)
    );

    // Grant is already a subset of req_valid; hold it off during reset.
    always_comb begin
        req_ready = rst_n ? grant : '0;
        xfer      = |req_ready;
    end

    // Operand issue and pointer advance past the winner on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            ptr   <= '0;
        end else if (xfer) begin
            mul_a <= req_a[win_id*WIDTH +: WIDTH];
            mul_b <= req_b[win_id*WIDTH +: WIDTH];
            ptr   <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
        end
    end

    // Tag shift register tracks each issued operand pair through the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= MUL_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= {xfer, MAX_ID_W'(win_id)};
            for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // Last stage lines up with mul_p; ids beyond ID_W are never reported.
    always_comb begin
        rsp_valid = tag_pipe[MUL_LAT].vld && ((tag_pipe[MUL_LAT].id >> ID_W) == '0);
        rsp_id    = tag_pipe[MUL_LAT].id[ID_W-1:0];
        rsp_data  = mul_p;
    end

    // Outstanding count: up on issue, down on response, unchanged on both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  in_flight <= '0;
        else if (xfer && !rsp_valid) in_flight <= in_flight + 3'd1;
        else if (!xfer && rsp_valid) in_flight <= in_flight - 3'd1;
    end

endmodule

// File: tb/tb_fix_mul_arbiter.sv
// Bench for fix_mul_arbiter: table vectors, directed corners and random traffic
// checked against a scoreboard model of the arbitration and return rules.
module tb_fix_mul_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int MUL_LAT = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   mul_a, mul_b, mul_p;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic [2:0]     in_flight;

    always #5 clk = ~clk;

    fix_mul_arbiter #(.WIDTH(W), .POINT_WIDTH(8), .N_REQ(N), .MUL_LAT(MUL_LAT), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .in_flight(in_flight)
    );

    // Q8.8 signed multiply, truncating the extra fraction bits.
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return W'(p >>> 8);
    endfunction

    // External multiplier with one cycle of latency.
    always @(posedge clk) mul_p <= fx_mul(mul_a, mul_b);

    // Reference: first valid index at or after ptr, wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct { int id; logic [W-1:0] d; int due; } exp_t;
    typedef struct { logic [N-1:0] v; logic [N-1:0] rdy; } vec_t;

    exp_t         q[$];
    int           m_ptr;
    logic [W-1:0] m_a, m_b;
    int           cyc;
    int           n_chk, n_fail;
    logic [N-1:0] last_ready;
    vec_t         tbl [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_a   = '0;
        m_b   = '0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
    endtask

    // One clock: drive valids, check ready/state/responses, then advance the model.
    task automatic cycle(input logic [N-1:0] v);
        int   w;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        #1;
        w          = pick(v, m_ptr);
        last_ready = req_ready;
        chk("ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("in_flight", 32'(in_flight), 32'(q.size()));
        chk("mul_a", 32'(mul_a), 32'(m_a));
        chk("mul_b", 32'(mul_b), 32'(m_b));
        if (rsp_valid) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_missing cyc=%0d actual=0 required=1", cyc);
            void'(q.pop_front());
        end
        @(posedge clk);
        if (w >= 0) begin
            e.id  = w;
            e.d   = fx_mul(req_a[w*W +: W], req_b[w*W +: W]);
            e.due = cyc + 1 + MUL_LAT;
            q.push_back(e);
            m_ptr = (w + 1) % N;
            m_a   = req_a[w*W +: W];
            m_b   = req_b[w*W +: W];
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        model_reset();

        // Reset state, with requests present to confirm ready stays low.
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 1.5 * 2.0 = 3.0.
        req_a[0 +: W] = 16'h0180;
        req_b[0 +: W] = 16'h0200;
        cycle(4'b0001);
        chk("t1_ready", 32'(last_ready), 32'h1);
        chk("t1_mul_a", 32'(mul_a), 32'h0180);
        cycle(4'b0000);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_data", 32'(rsp_data), 32'h0300);
        cycle(4'b0000);

        // Signed: -1.0 * 2.0 = -2.0 from requester 2.
        req_a[2*W +: W] = 16'hFF00;
        req_b[2*W +: W] = 16'h0200;
        cycle(4'b0100);
        cycle(4'b0000);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(rsp_id), 32'd2);
        chk("t2_rsp_data", 32'(rsp_data), 32'hFE00);
        cycle(4'b0000);

        // Table: fairness, sparse, idle, skip of a dropped pointer target, single requester.
        for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'b0001 << (i % 4)};
        for (int i = 8; i < 12; i++) tbl[i] = '{4'b1010, (i % 2 == 0) ? 4'b0010 : 4'b1000};
        for (int i = 12; i < 17; i++) tbl[i] = '{4'b0000, 4'b0000};
        tbl[17] = '{4'b1011, 4'b0001};
        tbl[18] = '{4'b1101, 4'b0100};
        tbl[19] = '{4'b0001, 4'b0001};
        tbl[20] = '{4'b0001, 4'b0001};
        tbl[21] = '{4'b0001, 4'b0001};
        do_reset();
        for (int i = 0; i < 22; i++) begin
            rand_ops();
            cycle(tbl[i].v);
            chk($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].rdy));
            if (i >= 2 && i < 8) chk("tbl_in_flight", 32'(in_flight), 32'd2);
        end
        repeat (3) cycle(4'b0000);

        // Reset one cycle after two issues: everything clears, nothing stale returns.
        rand_ops();
        cycle(4'b0011);
        cycle(4'b0011);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_in_flight", 32'(in_flight), 32'd0);
        chk("mid_mul_a", 32'(mul_a), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        repeat (3) cycle(4'b0000);
        cycle(4'b1111);
        chk("mid_first_grant", 32'(last_ready), 32'h1);
        repeat (3) cycle(4'b0000);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            cycle(N'($urandom));
        end
        repeat (4) cycle(4'b0000);
        chk("final_in_flight", 32'(in_flight), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
